// File: rtl/risc_alu_pkg.sv
// Shared definitions for the RISC ALU datapath: opcodes, flag positions and
// the helpers that decode an opcode into operand inversion and first carry-in.
package risc_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBB = 2'b11
    } alu_op_e;

    localparam int FLAG_W = 4;
    localparam int FLG_N  = 3;
    localparam int FLG_Z  = 2;
    localparam int FLG_C  = 1;
    localparam int FLG_V  = 0;

    // Subtract variants add the one's complement of B.
    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry into bit 0: forced for ADD/SUB, taken from the carry input for ADC/SBB.
    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADC:  c = cin;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// Combinational ripple-carry slice used as one pipeline segment. Also exposes
// the carry into its top bit so the last segment can form signed overflow.
module adder_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             c_in,
    output logic [SEG_W-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [SEG_W:0] carry;

    // Chain of full-adder cells from bit 0 upward.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = c_in;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out    = carry[SEG_W];
    assign c_msb_in = carry[SEG_W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The carry chain is cut into STAGES segments;
// operand slices not yet consumed ride along in skew registers and finished
// low result slices travel with them until the last segment registers the
// full sum and NZCV flags. A single stall condition freezes every stage.
module pipelined_adder
    import risc_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [1:0]        in_op,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic [FLAG_W-1:0] out_flags
);

    localparam int SEG_W = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_adder: STAGES must lie in 1..WIDTH");
    end
    if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // A held result at the output freezes the whole pipe, so upstream must wait too.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign b_eff    = op_inverts_b(in_op) ? ~in_b : in_b;
    assign cin0     = op_carry_in(in_op, in_cin);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [SEG_W-1:0]         seg_a;
        logic [SEG_W-1:0]         seg_b;
        logic [SEG_W-1:0]         seg_s;
        logic                     seg_cin;
        logic                     seg_cout;
        logic                     v_next;
        logic [(s+1)*SEG_W-1:0]   res_next;

        // Segment operands come from the ports for stage 0, else from the previous stage's skew registers.
        if (s == 0) begin : g_src
            assign seg_a    = in_a[SEG_W-1:0];
            assign seg_b    = b_eff[SEG_W-1:0];
            assign seg_cin  = cin0;
            assign v_next   = in_valid;
            assign res_next = seg_s;
        end else begin : g_src
            assign seg_a    = g_stage[s-1].g_reg.a_q[SEG_W-1:0];
            assign seg_b    = g_stage[s-1].g_reg.b_q[SEG_W-1:0];
            assign seg_cin  = g_stage[s-1].g_reg.c_q;
            assign v_next   = g_stage[s-1].g_reg.v_q;
            assign res_next = {seg_s, g_stage[s-1].g_reg.r_q};
        end

        if (s < STAGES - 1) begin : g_reg
            localparam int HI_W = WIDTH - (s + 1) * SEG_W;

            logic [HI_W-1:0]          a_q;
            logic [HI_W-1:0]          b_q;
            logic [HI_W-1:0]          a_next;
            logic [HI_W-1:0]          b_next;
            logic [(s+1)*SEG_W-1:0]   r_q;
            logic                     c_q;
            logic                     v_q;
            logic                     cmsb_unused;

            adder_segment #(.SEG_W(SEG_W)) u_seg (
                .a        (seg_a),
                .b        (seg_b),
                .c_in     (seg_cin),
                .s        (seg_s),
                .c_out    (seg_cout),
                .c_msb_in (cmsb_unused)
            );

            if (s == 0) begin : g_skew
                assign a_next = in_a[WIDTH-1:SEG_W];
                assign b_next = b_eff[WIDTH-1:SEG_W];
            end else begin : g_skew
                assign a_next = g_stage[s-1].g_reg.a_q[WIDTH-s*SEG_W-1:SEG_W];
                assign b_next = g_stage[s-1].g_reg.b_q[WIDTH-s*SEG_W-1:SEG_W];
            end

            // Intermediate stage register: advances every unstalled cycle, bubbles included.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    r_q <= '0;
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    v_q <= v_next;
                    c_q <= seg_cout;
                    r_q <= res_next;
                    a_q <= a_next;
                    b_q <= b_next;
                end
            end
        end else begin : g_last
            logic              seg_cmsb;
            logic [FLAG_W-1:0] flags_next;

            adder_segment #(.SEG_W(SEG_W)) u_seg (
                .a        (seg_a),
                .b        (seg_b),
                .c_in     (seg_cin),
                .s        (seg_s),
                .c_out    (seg_cout),
                .c_msb_in (seg_cmsb)
            );

            assign flags_next[FLG_N] = res_next[WIDTH-1];
            assign flags_next[FLG_Z] = ~|res_next;
            assign flags_next[FLG_C] = seg_cout;
            assign flags_next[FLG_V] = seg_cmsb ^ seg_cout;

            // Output register: result and flags only change when a valid beat lands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_flags <= '0;
                end else if (!stall) begin
                    out_valid <= v_next;
                    if (v_next) begin
                        out_sum   <= res_next;
                        out_flags <= flags_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder: a 32-bit/4-stage instance covers
// wrap, borrow, overflow, streaming, stalls and async reset; an 8-bit/1-stage
// instance covers the degenerate single-register configuration.
module tb_pipelined_adder;
    import risc_alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [35:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [3:0]  out_flags;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_a;
    logic [7:0]  s_in_b;
    logic [1:0]  s_in_op;
    logic        s_in_cin;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_sum;
    logic [3:0]  s_out_flags;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[8];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .in_op     (s_in_op),
        .in_cin    (s_in_cin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_flags (s_out_flags)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a wedged handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_beat(input vec_t v);
        in_a   = v.a;
        in_b   = v.b;
        in_op  = v.op;
        in_cin = v.cin;
    endtask

    // One isolated beat into an empty pipe; measures edges after the accept edge.
    task automatic run_single(input string tag, input vec_t v);
        int lat = 0;
        drive_beat(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output({tag, "_lat"}, 64'(lat), 64'(STAGES - 1));
        check_output({tag, "_res"}, {28'h0, out_flags, out_sum}, {28'h0, v.exp});
        @(posedge clk); #1;
    endtask

    // Streams all table vectors back-to-back, optionally holding out_ready low for a window.
    task automatic run_stream(input string tag, input int stall_at, input int stall_len);
        int          snd = 0;
        int          rcv = 0;
        int          first = -1;
        int          last = -1;
        logic        prev_stall = 1'b0;
        logic [35:0] held = '0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = (snd < 8);
            if (snd < 8) drive_beat(vecs[snd]);
            #1;
            if (!out_ready && out_valid) begin
                check_output($sformatf("%s_inrdy_c%0d", tag, cyc), 64'(in_ready), 64'd0);
                if (prev_stall)
                    check_output($sformatf("%s_hold_c%0d", tag, cyc), {28'h0, out_flags, out_sum}, {28'h0, held});
            end
            if (out_valid && out_ready) begin
                check_output($sformatf("%s_beat%0d", tag, rcv), {28'h0, out_flags, out_sum}, {28'h0, vecs[rcv].exp});
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            if (in_valid && in_ready) snd++;
            prev_stall = !out_ready && out_valid;
            held       = {out_flags, out_sum};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_output({tag, "_count"}, 64'(rcv), 64'd8);
        if (stall_len == 0) begin
            check_output({tag, "_first"}, 64'(first), 64'(STAGES));
            check_output({tag, "_span"}, 64'(last - first), 64'd7);
        end
        #1;
        check_output({tag, "_drained"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic apply_stimulus();
        vec_t v;
        int   stale = 0;

        // Reset values while rst_n is held low.
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = OP_ADD; in_cin = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_in_a = '0; s_in_b = '0; s_in_op = OP_ADD; s_in_cin = 1'b0;
        #2;
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_res", {28'h0, out_flags, out_sum}, 64'd0);
        check_output("rst_inrdy", 64'(in_ready), 64'd1);
        check_output("rst_w8_valid", 64'(s_out_valid), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Wrap to zero, then the two borrow/overflow corner cases of subtract.
        v = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, op: OP_ADD, cin: 1'b0, exp: {4'b0110, 32'h0000_0000}};
        run_single("add_wrap", v);
        v = '{a: 32'h8000_0000, b: 32'h0000_0001, op: OP_SUB, cin: 1'b0, exp: {4'b0011, 32'h7FFF_FFFF}};
        run_single("sub_ovf", v);
        v = '{a: 32'h0000_0000, b: 32'h0000_0001, op: OP_SUB, cin: 1'b0, exp: {4'b1000, 32'hFFFF_FFFF}};
        run_single("sub_borrow", v);

        // Mixed opcode stream, then the same stream with a three-cycle output stall.
        run_stream("stream", 100, 0);
        run_stream("stall", 5, 3);

        // Async reset asserted between edges while results are in flight.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drive_beat(vecs[4 + i]);
            @(posedge clk); #1;
        end
        check_output("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_output("rst_mid_valid", 64'(out_valid), 64'd0);
        check_output("rst_mid_res", {28'h0, out_flags, out_sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check_output("rst_no_stale", 64'(stale), 64'd0);
        run_single("post_rst", vecs[5]);

        // Single-stage 8-bit instance: one registered ripple add, latency 1.
        s_in_a = 8'h7F; s_in_b = 8'h00; s_in_op = OP_ADC; s_in_cin = 1'b1; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check_output("w8_adc_lat", 64'(s_out_valid), 64'd1);
        check_output("w8_adc_res", {52'h0, s_out_flags, s_out_sum}, {52'h0, 4'b1001, 8'h80});
        s_in_a = 8'h00; s_in_b = 8'h00; s_in_op = OP_SBB; s_in_cin = 1'b0; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check_output("w8_sbb_lat", 64'(s_out_valid), 64'd1);
        check_output("w8_sbb_res", {52'h0, s_out_flags, s_out_sum}, {52'h0, 4'b1000, 8'hFF});
        @(posedge clk); #1;
        check_output("w8_idle_valid", 64'(s_out_valid), 64'd0);
        check_output("w8_idle_hold", {52'h0, s_out_flags, s_out_sum}, {52'h0, 4'b1000, 8'hFF});
    endtask

    // Vector table with hand-computed {N,Z,C,V, sum}; cin is deliberately set on ADD/SUB rows where it must be ignored.
    initial begin
        vecs[0] = '{a: 32'h0000_0001, b: 32'h0000_0002, op: OP_ADD, cin: 1'b1, exp: {4'b0000, 32'h0000_0003}};
        vecs[1] = '{a: 32'h0000_FFFF, b: 32'h0000_0001, op: OP_ADC, cin: 1'b1, exp: {4'b0000, 32'h0001_0001}};
        vecs[2] = '{a: 32'h0000_0005, b: 32'h0000_0003, op: OP_SUB, cin: 1'b0, exp: {4'b0010, 32'h0000_0002}};
        vecs[3] = '{a: 32'h0000_0005, b: 32'h0000_0005, op: OP_SBB, cin: 1'b0, exp: {4'b1000, 32'hFFFF_FFFF}};
        vecs[4] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, op: OP_ADD, cin: 1'b0, exp: {4'b1001, 32'h8000_0000}};
        vecs[5] = '{a: 32'h1234_5678, b: 32'h1111_1111, op: OP_ADC, cin: 1'b0, exp: {4'b0000, 32'h2345_6789}};
        vecs[6] = '{a: 32'h0000_0010, b: 32'h0000_0001, op: OP_SBB, cin: 1'b1, exp: {4'b0010, 32'h0000_000F}};
        vecs[7] = '{a: 32'h00FF_FFFF, b: 32'h0000_0001, op: OP_ADD, cin: 1'b0, exp: {4'b0000, 32'h0100_0000}};
        apply_stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
